// File: rtl/fft_pkg.sv
// Shared constants, bus types and FSM encoding for the FFT peak detector.
package fft_pkg;

  localparam int N_PTS   = 1024;
  localparam int DW      = 16;
  localparam int SINK_W  = 39;
  localparam int MIN_BIN = 1;
  localparam int MAX_BIN = 511;
  localparam int BIN_W   = $clog2(N_PTS);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef logic [2*DW-1:0]  mag_t;
  typedef logic [BIN_W-1:0] bin_t;

  typedef enum logic [1:0] {IDLE, FRAME, DRAIN, HOLD} pk_state_t;

  localparam bin_t MIN_BIN_B = bin_t'(MIN_BIN);
  localparam bin_t MAX_BIN_B = bin_t'(MAX_BIN);
  localparam bin_t LAST_BIN  = bin_t'(N_PTS - 1);

  function automatic logic in_window(input bin_t b);
    return (b >= MIN_BIN_B) && (b <= MAX_BIN_B);
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// |X|^2 = re^2 + im^2 with bin/last sideband carried alongside.
// Latency 2 cycles; no backpressure, accepts a beat every cycle.
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic [BIN_W-1:0]     in_bin,
  input  logic                 in_last,
  output logic                 out_vld,
  output logic [2*DW-1:0]      out_mag,
  output logic [BIN_W-1:0]     out_bin,
  output logic                 out_last
);

  logic signed [2*DW-1:0] re_x, im_x;
  logic                   s1_vld, s1_last;
  mag_t                   s1_re2, s1_im2;
  bin_t                   s1_bin;

  // Sign-extend before squaring so the full product is kept.
  assign re_x = (2*DW)'(in_re);
  assign im_x = (2*DW)'(in_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_re2   <= '0;
      s1_im2   <= '0;
      s1_bin   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_mag  <= '0;
      out_bin  <= '0;
    end else begin
      s1_vld  <= in_vld;
      out_vld <= s1_vld;
      if (in_vld) begin
        s1_re2  <= $unsigned(re_x * re_x);
        s1_im2  <= $unsigned(im_x * im_x);
        s1_bin  <= in_bin;
        s1_last <= in_last;
      end
      // Each square is at most 2^(2*DW-2), so the sum cannot wrap.
      if (s1_vld) begin
        out_mag  <= s1_re2 + s1_im2;
        out_bin  <= s1_bin;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: rtl/fft_peak_detector.sv
// Finds the largest |X|^2 bin inside the search window of each FFT frame.
// Result valid 3 cycles after EOP; sink stalls from frame close until the result is taken.
module fft_peak_detector
  import fft_pkg::*;
(
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic [1:0]        sink_error,
  input  logic              sink_startofpacket,
  input  logic              sink_endofpacket,
  input  logic [SINK_W-1:0] sink_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [BIN_W-1:0]  result_bin,
  output logic [2*DW-1:0]   result_mag,
  output logic              result_error
);

  pk_state_t state, next_state;
  logic      rdy_q, accept, beat_vld, beat_last, err_q, err_nxt, last_done, upd;
  bin_t      bin_cnt, beat_bin, m_bin, max_bin, base_bin;
  mag_t      m_mag, max_mag, base_mag;
  logic      m_vld, m_last;
  cplx_t     beat;
  logic      unused_lsb;

  assign beat       = sink_data[SINK_W-1 -: 2*DW];
  assign unused_lsb = ^sink_data[SINK_W-2*DW-1:0];

  always_comb begin
    accept    = sink_valid && rdy_q;
    beat_vld  = accept && (sink_startofpacket || (state == FRAME));
    beat_bin  = ((state == FRAME) && !sink_startofpacket) ? bin_cnt : '0;
    beat_last = sink_endofpacket || (beat_bin == LAST_BIN);
    // EOP must coincide with the final bin; either one alone marks a bad length.
    err_nxt   = (sink_startofpacket ? 1'b0 : err_q) | (|sink_error)
              | (sink_endofpacket != (beat_bin == LAST_BIN));
    next_state = state;
    case (state)
      IDLE, FRAME: if (beat_vld) next_state = beat_last ? DRAIN : FRAME;
      DRAIN:       if (last_done) next_state = HOLD;
      HOLD:        if (result_ready) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Bin 0 only ever follows an SOP, so it restarts the running max in-line and
  // any stale beats of an abandoned frame ahead of it are overwritten.
  always_comb begin
    base_mag = (m_bin == '0) ? '0 : max_mag;
    base_bin = (m_bin == '0) ? MIN_BIN_B : max_bin;
    upd      = in_window(m_bin) && (m_mag > base_mag);
  end

  fft_mag_sq u_mag_sq (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .in_vld   (beat_vld),
    .in_re    (beat.re),
    .in_im    (beat.im),
    .in_bin   (beat_bin),
    .in_last  (beat_last),
    .out_vld  (m_vld),
    .out_mag  (m_mag),
    .out_bin  (m_bin),
    .out_last (m_last)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      rdy_q        <= 1'b0;
      bin_cnt      <= '0;
      err_q        <= 1'b0;
      last_done    <= 1'b0;
      max_mag      <= '0;
      max_bin      <= '0;
      result_bin   <= '0;
      result_mag   <= '0;
      result_error <= 1'b0;
    end else begin
      state <= next_state;
      rdy_q <= (next_state == IDLE) || (next_state == FRAME);
      if (beat_vld) begin
        bin_cnt <= beat_bin + 1'b1;
        err_q   <= err_nxt;
      end
      if (m_vld) begin
        max_mag <= upd ? m_mag : base_mag;
        max_bin <= upd ? m_bin : base_bin;
      end
      if ((state == DRAIN) && last_done) begin
        last_done    <= 1'b0;
        result_bin   <= max_bin;
        result_mag   <= max_mag;
        result_error <= err_q;
      end else if (m_vld && m_last) begin
        last_done <= 1'b1;
      end
    end
  end

  assign sink_ready   = rdy_q;
  assign result_valid = (state == HOLD);

endmodule
